// File: rtl/cp0_timer_irq_unit.sv
// CP0 timer/interrupt unit: prescaled Count, NUM_TIMERS sticky Compare channels,
// synchronised external IRQs, software IRQ bits, mask and a registered request.
module cp0_timer_irq_unit #(
    parameter int unsigned NUM_EXT     = 6,
    parameter int unsigned NUM_TIMERS  = 2,
    parameter int unsigned COUNT_W     = 32,
    parameter int unsigned COUNT_DIV   = 2,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned W          = 2 + NUM_EXT + NUM_TIMERS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reg_we,
    input  logic [2:0]            reg_addr,
    input  logic [31:0]           reg_wdata,
    output logic [31:0]           reg_rdata,
    input  logic                  status_ie,
    input  logic                  status_exl,
    input  logic                  hold_irq,
    input  logic [NUM_EXT-1:0]    ext_irq,
    output logic [W-1:0]          irq_vec,
    output logic                  irq_req,
    output logic [NUM_TIMERS-1:0] timer_hit
);

    localparam int unsigned PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_DIV - 1);

    logic [PW-1:0]                         presc_q, presc_d;
    logic [COUNT_W-1:0]                    count_q, count_d;
    logic [NUM_TIMERS-1:0][COUNT_W-1:0]    cmp_q, cmp_d;
    logic [NUM_TIMERS-1:0]                 flag_q, flag_d;
    logic [1:0]                            sw_q, sw_d;
    logic [W-1:0]                          mask_q, mask_d;
    logic [SYNC_STAGES-1:0][NUM_EXT-1:0]   sync_q;
    logic                                  irq_q, irq_d;

    logic                  tick;
    logic                  wr_count, wr_pend, wr_mask;
    logic [NUM_TIMERS-1:0] wr_cmp;
    logic [W-1:0]          pending;
    logic                  unused_wdata;

    assign unused_wdata = ^reg_wdata;

    assign tick      = (presc_q == PRESC_LAST);
    assign pending   = {flag_q, sync_q[SYNC_STAGES-1], sw_q};
    assign irq_vec   = pending & mask_q;
    assign irq_req   = irq_q;
    assign timer_hit = flag_q;

    always_comb begin
        wr_count = reg_we && (reg_addr == 3'd0);
        wr_pend  = reg_we && (reg_addr == 3'd1);
        wr_mask  = reg_we && (reg_addr == 3'd2);
        wr_cmp   = '0;
        for (int unsigned k = 0; k < NUM_TIMERS; k++) begin
            wr_cmp[k] = reg_we && (reg_addr == 3'(4 + k));
        end
    end

    always_comb begin
        count_d = count_q;
        presc_d = presc_q;
        // A Count write restarts the prescaler so the next increment is a full period away.
        if (wr_count) begin
            count_d = reg_wdata[COUNT_W-1:0];
            presc_d = '0;
        end else if (tick) begin
            count_d = count_q + 1'b1;
            presc_d = '0;
        end else begin
            presc_d = presc_q + 1'b1;
        end

        cmp_d  = cmp_q;
        flag_d = flag_q;
        for (int unsigned k = 0; k < NUM_TIMERS; k++) begin
            if (wr_cmp[k]) begin
                cmp_d[k]  = reg_wdata[COUNT_W-1:0];
                flag_d[k] = 1'b0;
            end else if ((cmp_q[k] != '0) && (count_q == cmp_q[k])) begin
                flag_d[k] = 1'b1;
            end
        end

        sw_d   = wr_pend ? reg_wdata[1:0] : sw_q;
        mask_d = wr_mask ? reg_wdata[W-1:0] : mask_q;
        irq_d  = status_ie && !status_exl && !hold_irq && (|irq_vec);
    end

    always_comb begin
        reg_rdata = '0;
        case (reg_addr)
            3'd0:    reg_rdata[COUNT_W-1:0] = count_q;
            3'd1:    reg_rdata[W-1:0]       = pending;
            3'd2:    reg_rdata[W-1:0]       = mask_q;
            default: begin
                for (int unsigned k = 0; k < NUM_TIMERS; k++) begin
                    if (reg_addr == 3'(4 + k)) begin
                        reg_rdata[COUNT_W-1:0] = cmp_q[k];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            count_q <= '0;
            cmp_q   <= '0;
            flag_q  <= '0;
            sw_q    <= '0;
            mask_q  <= '1;
            sync_q  <= '0;
            irq_q   <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            count_q   <= count_d;
            cmp_q     <= cmp_d;
            flag_q    <= flag_d;
            sw_q      <= sw_d;
            mask_q    <= mask_d;
            irq_q     <= irq_d;
            sync_q[0] <= ext_irq;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

endmodule
